// File: rtl/boot_pkg.sv
// boot_pkg: shared definitions for the boot loader.
//   boot_state_t : loader FSM states (LOAD_I, LOAD_D, HOLD, RUN)
//   BYTE_W       : width of one stream byte
//   width_of()   : counter/address width for n values, never narrower than 1
package boot_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    LOAD_I,
    LOAD_D,
    HOLD,
    RUN
  } boot_state_t;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs a byte stream into little-endian words.
//   clk          : clock
//   clear_i      : synchronous clear, drops any partial word
//   byte_valid_i : a byte is consumed this cycle
//   byte_data_i  : the byte
//   word_o       : assembled word, meaningful when word_valid_o = 1
//   word_valid_o : one-cycle strobe in the cycle the last byte of a word arrives
module word_assembler
  import boot_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         clear_i,
  input  logic                         byte_valid_i,
  input  logic [BYTE_W-1:0]            byte_data_i,
  output logic [BYTE_W*WORD_BYTES-1:0] word_o,
  output logic                         word_valid_o
);

  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam int CNT_W  = width_of(WORD_BYTES);

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [WORD_W-1:0]        shift_q, shift_d;
  logic [WORD_W+BYTE_W-1:0] wide;
  logic [WORD_W-1:0]        shifted;
  logic                     last_byte;

  // New bytes enter at the top and older bytes move down, so after
  // WORD_BYTES shifts the first byte sits in bits [7:0].
  assign wide      = {byte_data_i, shift_q};
  assign shifted   = wide[WORD_W+BYTE_W-1:BYTE_W];
  assign last_byte = (cnt_q == CNT_W'(WORD_BYTES - 1));
  assign word_o    = shifted;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    word_valid_o = 1'b0;
    if (byte_valid_i) begin
      shift_d = shifted;
      if (last_byte) begin
        cnt_d        = '0;
        word_valid_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: streams a byte image into instruction then data memory and
// sequences the core reset around the load.
//   clk, reset             : clock, synchronous active-high reset
//   in_valid/in_data       : input byte stream; in_ready = loader takes a byte
//   reload                 : one-cycle request to reload (honoured only in RUN)
//   imem_we/addr/wdata     : registered instruction-memory write port
//   dmem_we/addr/wdata     : registered data-memory write port
//   core_reset             : held high until images are loaded plus N_RESET cycles
//   done                   : core released and running
module boot_loader
  import boot_pkg::*;
#(
  parameter int WORD_BYTES      = 4,
  parameter int IMEM_SIZE_BYTES = 64,
  parameter int DMEM_SIZE_BYTES = 32,
  parameter int N_RESET         = 10
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             in_valid,
  input  logic [7:0]                                       in_data,
  output logic                                             in_ready,
  input  logic                                             reload,
  output logic                                             imem_we,
  output logic [width_of(IMEM_SIZE_BYTES/WORD_BYTES)-1:0] imem_addr,
  output logic [8*WORD_BYTES-1:0]                          imem_wdata,
  output logic                                             dmem_we,
  output logic [width_of(DMEM_SIZE_BYTES/WORD_BYTES)-1:0] dmem_addr,
  output logic [8*WORD_BYTES-1:0]                          dmem_wdata,
  output logic                                             core_reset,
  output logic                                             done
);

  localparam int IMEM_WORDS = IMEM_SIZE_BYTES / WORD_BYTES;
  localparam int DMEM_WORDS = DMEM_SIZE_BYTES / WORD_BYTES;
  localparam int IAW        = width_of(IMEM_WORDS);
  localparam int DAW        = width_of(DMEM_WORDS);
  localparam int CW         = width_of((IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS);
  localparam int HW         = width_of(N_RESET + 1);
  localparam int WORD_W     = 8 * WORD_BYTES;

  boot_state_t       state_q, state_d;
  logic [CW-1:0]     word_cnt_q, word_cnt_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;

  logic              in_ready_q, core_reset_q, done_q;
  logic              imem_we_q, dmem_we_q;
  logic [IAW-1:0]    imem_addr_q;
  logic [DAW-1:0]    dmem_addr_q;
  logic [WORD_W-1:0] imem_wdata_q, dmem_wdata_q;

  logic              accept, take_reload, asm_clear;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic              imem_write, dmem_write;

  assign accept      = in_valid & in_ready;
  assign take_reload = (state_q == RUN) & reload;
  assign asm_clear   = reset | take_reload;
  assign imem_write  = word_valid & (state_q == LOAD_I);
  assign dmem_write  = word_valid & (state_q == LOAD_D);

  word_assembler #(
    .WORD_BYTES(WORD_BYTES)
  ) u_asm (
    .clk         (clk),
    .clear_i     (asm_clear),
    .byte_valid_i(accept),
    .byte_data_i (in_data),
    .word_o      (word),
    .word_valid_o(word_valid)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      LOAD_I: begin
        if (word_valid) begin
          if (word_cnt_q == CW'(IMEM_WORDS - 1)) begin
            state_d    = LOAD_D;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + CW'(1);
          end
        end
      end
      LOAD_D: begin
        if (word_valid) begin
          if (word_cnt_q == CW'(DMEM_WORDS - 1)) begin
            state_d    = HOLD;
            word_cnt_d = '0;
            hold_cnt_d = HW'(N_RESET);
          end else begin
            word_cnt_d = word_cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q - HW'(1);
        if (hold_cnt_d == '0) state_d = RUN;
      end
      RUN: begin
        if (take_reload) begin
          state_d    = LOAD_I;
          word_cnt_d = '0;
        end
      end
      default: state_d = LOAD_I;
    endcase
  end

  // Status outputs are registered from the next state, so they line up with
  // the state the FSM is in during the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD_I;
      word_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      in_ready_q   <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      in_ready_q   <= (state_d == LOAD_I) || (state_d == LOAD_D);
      core_reset_q <= (state_d != RUN);
      done_q       <= (state_d == RUN);
      imem_we_q    <= imem_write;
      dmem_we_q    <= dmem_write;
      if (imem_write) begin
        imem_addr_q  <= IAW'(word_cnt_q);
        imem_wdata_q <= word;
      end
      if (dmem_write) begin
        dmem_addr_q  <= DAW'(word_cnt_q);
        dmem_wdata_q <= word;
      end
    end
  end

  // Reset also masks the outputs combinationally so they are quiet in the
  // very cycle reset is asserted, and a write queued for that cycle is dropped.
  assign in_ready   = in_ready_q & ~reset;
  assign core_reset = core_reset_q | reset;
  assign done       = done_q & ~reset;
  assign imem_we    = imem_we_q & ~reset;
  assign dmem_we    = dmem_we_q & ~reset;
  assign imem_addr  = reset ? '0 : imem_addr_q;
  assign dmem_addr  = reset ? '0 : dmem_addr_q;
  assign imem_wdata = reset ? '0 : imem_wdata_q;
  assign dmem_wdata = reset ? '0 : dmem_wdata_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized self-checking bench for boot_loader. A byte-level
// reference model (bytes accepted per load, pending word, cycle of the last
// image byte) predicts ready/reset/done and every memory write each cycle.
module tb_boot_loader;

  localparam int WB      = 4;
  localparam int IBYTES  = 64;
  localparam int DBYTES  = 32;
  localparam int N_RESET = 10;
  localparam int IWORDS  = IBYTES / WB;
  localparam int TOTAL   = IBYTES + DBYTES;

  logic        clk = 1'b0;
  logic        reset, in_valid, reload;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, dmem_we, core_reset, done;
  logic [3:0]  imem_addr;
  logic [2:0]  dmem_addr;
  logic [31:0] imem_wdata, dmem_wdata;

  always #5 clk = ~clk;

  boot_loader #(
    .WORD_BYTES     (WB),
    .IMEM_SIZE_BYTES(IBYTES),
    .DMEM_SIZE_BYTES(DBYTES),
    .N_RESET        (N_RESET)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .core_reset(core_reset),
    .done      (done)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int          cyc = 0;
  bit          r_prev = 1'b0;
  int          exp_bytes = 0;
  logic [31:0] part = '0;
  bit          pend_i = 1'b0, pend_d = 1'b0;
  int          pend_addr = 0;
  logic [31:0] pend_data = '0;
  int          t_last = 0;

  // observations
  logic [31:0] imem_seen [IWORDS];
  logic [31:0] dmem_seen [DBYTES/WB];
  int          iw_cnt = 0, dw_cnt = 0;
  int          last_dw_cyc = 0, done_rise_cyc = 0;
  bit          done_prev = 1'b0;

  logic [7:0]  stim_q [$];
  bit          acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input int w);
    return {stim_q[4*w+3], stim_q[4*w+2], stim_q[4*w+1], stim_q[4*w]};
  endfunction

  task automatic tick(input bit rst, input bit v, input logic [7:0] d, input bit rl,
                      output bit accepted);
    bit quiet, e_ready, e_cr, e_done, e_iwe, e_dwe;
    int k, widx;
    reset = rst; in_valid = v; in_data = d; reload = rl;
    #1;
    quiet = rst || r_prev;
    if (quiet) begin
      e_ready = 1'b0; e_cr = 1'b1; e_done = 1'b0;
    end else if (exp_bytes < TOTAL) begin
      e_ready = 1'b1; e_cr = 1'b1; e_done = 1'b0;
    end else begin
      e_ready = 1'b0; e_cr = (cyc <= t_last + N_RESET); e_done = !e_cr;
    end
    e_iwe = pend_i && !rst;
    e_dwe = pend_d && !rst;
    check("in_ready", in_ready, e_ready);
    check("core_reset", core_reset, e_cr);
    check("done", done, e_done);
    check("imem_we", imem_we, e_iwe);
    check("dmem_we", dmem_we, e_dwe);
    if (e_iwe) begin
      check("imem_addr", imem_addr, pend_addr);
      check("imem_wdata", imem_wdata, pend_data);
      imem_seen[pend_addr] = imem_wdata;
      iw_cnt++;
    end
    if (e_dwe) begin
      check("dmem_addr", dmem_addr, pend_addr);
      check("dmem_wdata", dmem_wdata, pend_data);
      dmem_seen[pend_addr] = dmem_wdata;
      dw_cnt++;
      last_dw_cyc = cyc;
    end
    if (quiet) begin
      check("reset_imem_addr", imem_addr, 0);
      check("reset_imem_wdata", imem_wdata, 0);
      check("reset_dmem_addr", dmem_addr, 0);
      check("reset_dmem_wdata", dmem_wdata, 0);
    end
    if (done && !done_prev) done_rise_cyc = cyc;
    done_prev = done;
    accepted = v && in_ready;

    pend_i = 1'b0;
    pend_d = 1'b0;
    if (rst) begin
      exp_bytes = 0;
    end else begin
      if (v && e_ready) begin
        k = exp_bytes % WB;
        part[8*k +: 8] = d;
        exp_bytes++;
        if (k == WB - 1) begin
          widx = exp_bytes / WB - 1;
          if (widx < IWORDS) begin
            pend_i = 1'b1; pend_addr = widx;
          end else begin
            pend_d = 1'b1; pend_addr = widx - IWORDS;
          end
          pend_data = part;
        end
        if (exp_bytes == TOTAL) t_last = cyc;
      end
      if (rl && e_done) exp_bytes = 0;
    end
    r_prev = rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: back-to-back, 1: every other cycle plus a 5-cycle gap, 2: random valid
  task automatic send(input int mode, input int reload_at);
    int idx = 0;
    int budget = 0;
    bit v, rl, rl_sent = 1'b0, a;
    while (idx < stim_q.size() && budget < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (budget % 2 == 0) && !(budget >= 6 && budget < 11);
        default: v = 1'($urandom_range(0, 1));
      endcase
      rl = (idx == reload_at) && !rl_sent;
      if (rl) rl_sent = 1'b1;
      tick(1'b0, v, stim_q[idx], rl, a);
      if (a) idx++;
      budget++;
    end
    check("send_progress", idx, stim_q.size());
  endtask

  task automatic idle(input int n, input bit v);
    bit a;
    for (int i = 0; i < n; i++) tick(1'b0, v, 8'($urandom), 1'b0, a);
  endtask

  task automatic do_reset(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00, 1'b0, a);
  endtask

  task automatic fill_random(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
  endtask

  task automatic clear_obs();
    iw_cnt = 0;
    dw_cnt = 0;
    for (int i = 0; i < IWORDS; i++) imem_seen[i] = '0;
    for (int i = 0; i < DBYTES/WB; i++) dmem_seen[i] = '0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;

    // 1: reset, then two known instruction words
    do_reset(3);
    clear_obs();
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send(0, -1);
    idle(1, 1'b0);
    check("t1_imem0", imem_seen[0], 32'h0000_0013);
    check("t1_imem1", imem_seen[1], 32'h0010_0093);
    check("t1_imem_writes", iw_cnt, 2);
    check("t1_dmem_writes", dw_cnt, 0);

    // 2: same stream, throttled with a gap
    do_reset(3);
    clear_obs();
    send(1, -1);
    idle(1, 1'b0);
    check("t2_imem0", imem_seen[0], 32'h0000_0013);
    check("t2_imem1", imem_seen[1], 32'h0010_0093);
    check("t2_imem_writes", iw_cnt, 2);
    check("t2_dmem_writes", dw_cnt, 0);

    // 3: full image back-to-back, then bytes presented while not ready
    do_reset(3);
    clear_obs();
    fill_random(TOTAL);
    send(0, -1);
    idle(N_RESET + 8, 1'b1);
    check("t3_imem_writes", iw_cnt, IWORDS);
    check("t3_dmem_writes", dw_cnt, DBYTES / WB);
    check("t3_imem15", imem_seen[IWORDS-1], word_at(IWORDS - 1));
    check("t3_dmem7", dmem_seen[DBYTES/WB-1], word_at(TOTAL / WB - 1));
    check("t3_hold_len", done_rise_cyc - last_dw_cyc, N_RESET);
    check("t3_done", done, 1'b1);

    // 4: reset mid-word discards the partial word
    do_reset(3);
    fill_random(5);
    send(0, -1);
    do_reset(2);
    clear_obs();
    fill_random(TOTAL);
    send(2, -1);
    idle(N_RESET + 4, 1'b0);
    check("t4_imem0", imem_seen[0], word_at(0));
    check("t4_imem_writes", iw_cnt, IWORDS);
    check("t4_done", done, 1'b1);

    // 5: reload from RUN overwrites both images
    tick(1'b0, 1'b0, 8'h00, 1'b1, acc);
    clear_obs();
    fill_random(TOTAL);
    send(2, -1);
    idle(N_RESET + 4, 1'b0);
    check("t5_imem0", imem_seen[0], word_at(0));
    check("t5_dmem0", dmem_seen[0], word_at(IWORDS));
    check("t5_imem_writes", iw_cnt, IWORDS);
    check("t5_dmem_writes", dw_cnt, DBYTES / WB);

    // 6: reload pulses during LOAD_D and HOLD are ignored
    tick(1'b0, 1'b0, 8'h00, 1'b1, acc);
    clear_obs();
    fill_random(TOTAL);
    send(0, IBYTES + 6);
    tick(1'b0, 1'b0, 8'h00, 1'b1, acc);
    tick(1'b0, 1'b0, 8'h00, 1'b0, acc);
    tick(1'b0, 1'b0, 8'h00, 1'b1, acc);
    idle(N_RESET + 4, 1'b1);
    check("t6_imem_writes", iw_cnt, IWORDS);
    check("t6_dmem_writes", dw_cnt, DBYTES / WB);
    check("t6_dmem7", dmem_seen[DBYTES/WB-1], word_at(TOTAL / WB - 1));
    check("t6_hold_len", done_rise_cyc - last_dw_cyc, N_RESET);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
